// File: rtl/ram_fifo_controller_pkg.sv
// Shared definitions for the RAM-backed FIFO controller.
// Holds the default geometry, the pointer width (one wrap bit above the
// RAM address) and the pointer type for the default configuration.
package ram_fifo_controller_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH           = 2 ** FIFO_ADDR_WIDTH;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/ram_fifo_controller_ring_pointer.sv
// ring_pointer: WIDTH-bit up-counter used as a FIFO ring pointer.
// Ports:
//   Clock, Reset  - rising-edge clock, asynchronous active-low clear
//   en            - advance by one at the next edge
//   value         - registered pointer
//   next_value    - combinational value the pointer takes at the next edge
// Wrap is natural modulo 2**WIDTH.
module ring_pointer #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

  assign next_value = value + WIDTH'(en);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) value <= '0;
    else        value <= next_value;
  end

endmodule

// File: rtl/ram_fifo_controller.sv
// ram_fifo_controller: ring-buffer FIFO control for an external RAM with
// a registered read port and separate read/write addresses. The RAM output
// register serves as the FIFO head register, so one pop per cycle is
// possible.
// Ports:
//   Clock, Reset                 - clock, asynchronous active-low reset
//   iPushValid/oPushReady/iPushData - push handshake (ready = not full)
//   iPopReady/oPopValid/oPopData    - pop handshake, data from RAM output
//   oCount                       - entries stored, 0..DEPTH
//   oRamWriteEnable/Address, oRamDataIn - RAM write port
//   oRamReadAddress, iRamDataOut - RAM read port
module ram_fifo_controller
  import ram_fifo_controller_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPushValid,
  output logic                  oPushReady,
  input  logic [DATA_WIDTH-1:0] iPushData,
  input  logic                  iPopReady,
  output logic                  oPopValid,
  output logic [DATA_WIDTH-1:0] oPopData,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress,
  input  logic [DATA_WIDTH-1:0] iRamDataOut
);

  localparam int RING_PTR_W = ADDR_WIDTH + 1;
  localparam int RING_DEPTH = 2 ** ADDR_WIDTH;

  logic [RING_PTR_W-1:0] wr_ptr, wr_next;
  logic [RING_PTR_W-1:0] rd_ptr, rd_next;
  logic                  push, pop, full;
  logic                  pop_valid;

  assign oCount     = wr_ptr - rd_ptr;
  assign full       = (oCount == RING_PTR_W'(RING_DEPTH));
  // Ready comes from registered pointers only: a pop in the same cycle
  // does not free a slot for a push while full.
  assign oPushReady = !full;
  assign push       = iPushValid && oPushReady;
  assign pop        = iPopReady && pop_valid;

  ring_pointer #(.WIDTH(RING_PTR_W)) u_wr_ptr (
    .Clock      (Clock),
    .Reset      (Reset),
    .en         (push),
    .value      (wr_ptr),
    .next_value (wr_next)
  );

  ring_pointer #(.WIDTH(RING_PTR_W)) u_rd_ptr (
    .Clock      (Clock),
    .Reset      (Reset),
    .en         (pop),
    .value      (rd_ptr),
    .next_value (rd_next)
  );

  assign oRamWriteEnable  = push;
  assign oRamWriteAddress = wr_ptr[ADDR_WIDTH-1:0];
  assign oRamDataIn       = iPushData;

  // Reading at the post-pop head makes the RAM register present the new
  // head one edge later; a held address keeps the output stable.
  assign oRamReadAddress  = rd_next[ADDR_WIDTH-1:0];
  assign oPopData         = iRamDataOut;
  assign oPopValid        = pop_valid;

  // Compare against the pre-edge write pointer: a word written at this
  // edge is not yet readable, so it becomes poppable one edge later.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) pop_valid <= 1'b0;
    else        pop_valid <= (wr_ptr != rd_next);
  end

  logic unused_wr_next;
  assign unused_wr_next = ^wr_next;

endmodule

// File: tb/tb_ram_fifo_controller.sv
module tb_ram_fifo_controller;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH_TB = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iPushValid, iPopReady;
  logic [DW-1:0] iPushData;
  logic          oPushReady, oPopValid, oRamWriteEnable;
  logic [DW-1:0] oPopData, oRamDataIn, iRamDataOut;
  logic [AW:0]   oCount;
  logic [AW-1:0] oRamWriteAddress, oRamReadAddress;

  always #5 Clock = ~Clock;

  ram_fifo_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iPushValid       (iPushValid),
    .oPushReady       (oPushReady),
    .iPushData        (iPushData),
    .iPopReady        (iPopReady),
    .oPopValid        (oPopValid),
    .oPopData         (oPopData),
    .oCount           (oCount),
    .oRamWriteEnable  (oRamWriteEnable),
    .oRamWriteAddress (oRamWriteAddress),
    .oRamDataIn       (oRamDataIn),
    .oRamReadAddress  (oRamReadAddress),
    .iRamDataOut      (iRamDataOut)
  );

  // RAM beside the controller: registered read, old data on same-address access.
  logic [DW-1:0] mem [DEPTH_TB];
  always_ff @(posedge Clock) begin
    iRamDataOut <= mem[oRamReadAddress];
    if (oRamWriteEnable) mem[oRamWriteAddress] <= oRamDataIn;
  end

  int tests  = 0;
  int errors = 0;

  // Reference model: queue of stored words, head visibility flag, write slot.
  logic [DW-1:0] q[$];
  bit            m_valid = 1'b0;
  int            wr_idx  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; applies inputs for one cycle.
  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit pr);
    bit push_acc, pop_acc;
    iPushValid = pv; iPushData = pd; iPopReady = pr;
    #1;
    push_acc = pv && (q.size() < DEPTH_TB);
    pop_acc  = pr && m_valid;
    check("push_ready", oPushReady, q.size() < DEPTH_TB);
    check("ram_we", oRamWriteEnable, push_acc);
    if (push_acc) begin
      check("ram_waddr", oRamWriteAddress, wr_idx % DEPTH_TB);
      check("ram_din", oRamDataIn, pd);
    end
    @(posedge Clock);
    if (pop_acc) void'(q.pop_front());
    // a word written at this edge is visible only after the next one
    m_valid = (q.size() > 0);
    if (push_acc) begin
      q.push_back(pd);
      wr_idx++;
    end
    #1;
    check("count", oCount, q.size());
    check("pop_valid", oPopValid, m_valid);
    if (m_valid) check("pop_data", oPopData, q[0]);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() > 0); i++) step(1'b0, '0, 1'b1);
    check("drained", oCount, 0);
  endtask

  initial begin
    Reset = 1'b0; iPushValid = 1'b0; iPopReady = 1'b0; iPushData = '0;
    #12;
    check("rst_count", oCount, 0);
    check("rst_valid", oPopValid, 0);
    check("rst_ready", oPushReady, 1);
    check("rst_we", oRamWriteEnable, 0);
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;

    // first push, latency
    step(1'b1, 16'h1111, 1'b0);
    check("lat_count1", oCount, 1);
    check("lat_valid_e1", oPopValid, 0);
    step(1'b0, '0, 1'b0);
    check("lat_valid_e2", oPopValid, 1);
    check("lat_data", oPopData, 16'h1111);
    drain();

    // fill, overflow attempt, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 16'hA000 + DW'(i), 1'b0);
    check("full_count", oCount, 8);
    check("full_ready", oPushReady, 0);
    step(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", oPopData, 16'hA000 + DW'(i));
      step(1'b0, '0, 1'b1);
    end
    check("empty_valid", oPopValid, 0);
    check("empty_count", oCount, 0);

    // streaming
    for (int i = 0; i < 40; i++) step(1'b1, 16'hC000 + DW'(i), 1'b1);
    check("stream_count", oCount, 2);
    drain();

    // simultaneous push and pop at count 1
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 16'h5555, 1'b1);
    check("simul_count", oCount, 1);
    step(1'b0, '0, 1'b0);
    check("simul_data", oPopData, 16'h5555);
    drain();

    // asynchronous reset mid-cycle with 5 entries
    for (int i = 0; i < 5; i++) step(1'b1, 16'hD000 + DW'(i), 1'b0);
    check("pre_rst_count", oCount, 5);
    iPushValid = 1'b0; iPopReady = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("arst_count", oCount, 0);
    check("arst_valid", oPopValid, 0);
    check("arst_waddr", oRamWriteAddress, 0);
    check("arst_raddr", oRamReadAddress, 0);
    q.delete(); m_valid = 1'b0; wr_idx = 0;
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    step(1'b1, 16'h7777, 1'b0);
    step(1'b0, '0, 1'b0);
    check("post_rst_data", oPopData, 16'h7777);
    step(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_controller.md
# ram_fifo_controller

Ring-buffer FIFO controller that sits directly upstream of the team's single-read-port RAM, which has a registered read and separate read/write addresses. It accepts words on a valid/ready push port and drives the RAM write port. It steers the RAM read address so that the RAM output register itself acts as the FIFO head register, giving one pop per cycle. The RAM is instantiated beside this block by the parent; this block holds only pointers and flags.

## Interface
Parameters:
- DATA_WIDTH, 16, width of stored word
- ADDR_WIDTH, 3, RAM address width; DEPTH = 2**ADDR_WIDTH entries

Ports:
- Clock  in  1  sole clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- iPushValid  in  1  producer has a word
- oPushReady  out  1  FIFO can accept (not full)
- iPushData  in  DATA_WIDTH  word to store
- iPopReady  in  1  consumer takes head word this cycle
- oPopValid  out  1  oPopData holds a valid head word
- oPopData  out  DATA_WIDTH  head word; wired from iRamDataOut
- oCount  out  ADDR_WIDTH+1  entries stored (0..DEPTH)
- oRamWriteEnable  out  1  to RAM write enable
- oRamWriteAddress  out  ADDR_WIDTH  to RAM write address
- oRamDataIn  out  DATA_WIDTH  to RAM data in
- oRamReadAddress  out  ADDR_WIDTH  to RAM read address
- iRamDataOut  in  DATA_WIDTH  from RAM registered data out

## Operation
- State: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, with a wrap bit in the MSB; oPopValid register.
- oCount = wr_ptr − rd_ptr, modulo 2**(ADDR_WIDTH+1). Full when oCount == DEPTH. Empty when oCount == 0.
- oPushReady = !full, combinational from registered pointers.
- push = iPushValid && oPushReady.
- oRamWriteEnable = push; oRamWriteAddress = wr_ptr[ADDR_WIDTH-1:0]; oRamDataIn = iPushData.
- wr_ptr increments on push.
- pop = iPopReady && oPopValid; rd_ptr increments on pop. rd_next = rd_ptr + pop.
- oRamReadAddress = rd_next[ADDR_WIDTH-1:0], combinational. The RAM output therefore shows the entry at the new head one edge later. A held read address keeps the RAM output stable.
- oPopValid <= (wr_ptr != rd_next), using the pre-edge wr_ptr. A word written at edge E is in the RAM array only after E. It becomes poppable at the edge after E, never in the same edge.
- Pointers wrap naturally at 2**(ADDR_WIDTH+1). The RAM index wraps at DEPTH.
- Push while full: ignored, since oPushReady is low; RAM is not written.
- Pop while !oPopValid: ignored.
- Simultaneous push and pop: both take effect; oCount unchanged.
- When full, a same-cycle pop does not enable a push; ready reflects registered state only.
- The writer can never address an unpopped slot, so the held head word cannot be overwritten.

## Timing
- Reset asserted: wr_ptr=0, rd_ptr=0, oPopValid=0, oCount=0, oPushReady=1, oRamWriteEnable=0 while iPushValid is low.
- oPopData is don't-care while oPopValid=0. RAM contents are not cleared.
- Reset mid-operation discards all entries. The first push after release behaves as into an empty FIFO.
- Latency: push accepted at edge E gives oPopValid=1 after edge E+1, when the FIFO was empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- Back-to-back pops with ≥2 entries: oPopValid stays 1. oPopData changes to the next entry after each pop edge.
- The RAM must provide old-data read-during-write semantics on a same-address access. Its read register updates every cycle.

## Structure
- Shared package holds:
  - PTR_WIDTH = ADDR_WIDTH+1
  - DEPTH = 2**ADDR_WIDTH
  - a pointer typedef
- Natural sub-module: ring_pointer. It is a PTR_WIDTH up-counter with enable, async active-low clear, a registered output and a combinational next-value output. It is instantiated twice, for write and read.
- No other sub-modules. The RAM stays outside this block.

## Test plan
- Reset, then push 0x1111 at edge 1 with iPopReady=0:
  - oCount=1 after edge 1.
  - oPopValid=1 after edge 2.
  - oPopData=0x1111.
- Fill with 8 pushes of 0xA000..0xA007:
  - oPushReady=0 and oCount=8.
  - A 9th push (0xBEEF) is not written; oRamWriteEnable stays 0.
- From full, pop continuously:
  - oPopData reads 0xA000..0xA007 on consecutive cycles.
  - oPopValid drops after the 8th pop; oCount=0.
- Streaming push and pop every cycle for 40 words:
  - Data emerges in order with no bubbles after the initial 2-cycle latency.
  - Pointers wrap; oCount is constant.
- With oCount=1, push 0x5555 and pop in the same cycle:
  - oCount stays 1.
  - Next oPopData=0x5555, valid one edge later. There is no stale or duplicate pop.
- Assert Reset asynchronously mid-cycle with oCount=5:
  - oPopValid, oCount and pointers go to 0 immediately, without waiting for a clock edge.
  - After release, a push of 0x7777 pops as 0x7777.
